// File: rtl/bitstream_loader.sv
// Buffers a DEPTH-byte configuration image from the host and streams it to the fabric
// over a valid/ready handshake. Optional running checksum under BITSTREAM_CHECKSUM_EN.
//
// state  | meaning
// S_IDLE | buffer writable, waiting for start
// S_SEND | streaming buffer bytes, cfg_valid high
// S_FIN  | one-cycle done pulse after the last byte
module bitstream_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [7:0]        o_cfg_data,
    output logic              o_cfg_valid,
    input  logic              i_cfg_ready,
    output logic              o_cfg_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_buf [DEPTH];
    logic [ADDR_W-1:0] r_idx;
    logic              w_send;
    logic              w_xfer;
    logic              w_at_last;

    assign w_send    = (r_state == S_SEND);
    // abort wins over a same-cycle ready, so no byte counts as transferred then
    assign w_xfer    = w_send && i_cfg_ready && !i_abort;
    assign w_at_last = (r_idx == ADDR_W'(DEPTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (i_abort)                  w_state_nxt = S_IDLE;
                else if (w_xfer && w_at_last) w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= 8'h00;
        end else if (r_state == S_IDLE && i_wr_en) begin
            r_buf[i_wr_addr] <= i_wr_data;
        end
    end

    // Index parks at DEPTH-1 through FIN and clears everywhere outside SEND.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
        end else if (!w_send || i_abort) begin
            r_idx <= '0;
        end else if (w_xfer && !w_at_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_cfg_data  = w_send ? r_buf[r_idx] : 8'h00;
    assign o_cfg_valid = w_send;
    assign o_busy      = w_send;
    assign o_cfg_last  = w_send && w_at_last;
    assign o_done      = (r_state == S_FIN);

`ifdef BITSTREAM_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_checksum <= 8'h00;
        end else if (r_state == S_IDLE && i_start) begin
            r_checksum <= 8'h00;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + o_cfg_data;
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = 8'h00;
`endif

endmodule
